prt_dptx_scrm_ctl: RTL and testbench

// Scrambler reset scheduler and enable sequencer, placed directly upstream of the DP TX scrambler.
// - Replaces every P_SR_INTVL-th qualifying symbol with a scrambler-reset symbol:
//   - SST: BS becomes SR.
//   - MST: MTPH_BS becomes MTPH_SR.
// - Drives the scrambler enable so that it rises on the same output cycle as the first SR.
// - Drops the scrambler enable at once when scrambling is withdrawn, or while a training pattern is active.
//

---
 rtl/prt_dptx_scrm_ctl.sv | 130 +++++++++++++
 tb/tb_prt_dptx_scrm_ctl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/prt_dptx_scrm_ctl.sv
// Scrambler reset scheduler: swaps every INTVL-th BS / MTPH_BS for SR / MTPH_SR
// and raises the scrambler enable on the same output beat as the first SR.
module prt_dptx_scrm_ctl #(
    parameter int P_SIM      = 0,
    parameter int P_SPL      = 2,
    parameter int P_SYM_W    = 5,
    parameter int P_SR_INTVL = 512
) (
    input  logic                     CLK_IN,
    input  logic                     RST_IN,
    input  logic                     CTL_EN_IN,
    input  logic                     CTL_MST_IN,
    input  logic                     CTL_TPS_IN,
    input  logic [P_SPL*P_SYM_W-1:0] LNK_SYM_IN,
    input  logic [P_SPL*8-1:0]       LNK_DAT_IN,
    output logic [P_SPL*P_SYM_W-1:0] LNK_SYM_OUT,
    output logic [P_SPL*8-1:0]       LNK_DAT_OUT,
    output logic                     SCRM_EN_OUT,
    output logic                     STA_LOCK_OUT,
    output logic [15:0]              STA_SR_CNT_OUT
);

    localparam int INTVL = (P_SIM != 0) ? 8 : P_SR_INTVL;
    localparam int CW    = $clog2(INTVL);

    localparam logic [P_SYM_W-1:0] SYM_BS      = P_SYM_W'(1);
    localparam logic [P_SYM_W-1:0] SYM_SR      = P_SYM_W'(2);
    localparam logic [P_SYM_W-1:0] SYM_MTPH_BS = P_SYM_W'(3);
    localparam logic [P_SYM_W-1:0] SYM_MTPH_SR = P_SYM_W'(4);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_BS, S_RUN} state_t;

    state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_d, cnt_walk;
    logic          mst_q;
    logic          abort, q_any, scrm_en_nxt;
    logic [2:0]    ins_n, sr_add;
    logic [16:0]   sr_sum;
    logic [P_SYM_W-1:0] q_sym, sr_sym;
    logic [P_SPL-1:0][P_SYM_W-1:0] sym_in, sym_sub, sym_nxt;

    assign sym_in       = LNK_SYM_IN;
    assign STA_LOCK_OUT = (state == S_RUN);
    assign sr_sum       = {1'b0, STA_SR_CNT_OUT} + {14'd0, sr_add};

    // Lane walk: each qualifying symbol is counted in sublane order; the one
    // seen at cnt == 0 becomes SR. WAIT_BS holds cnt at 0, so its first q is the SR.
    always_comb begin
        q_sym    = CTL_MST_IN ? SYM_MTPH_BS : SYM_BS;
        sr_sym   = CTL_MST_IN ? SYM_MTPH_SR : SYM_SR;
        sym_sub  = sym_in;
        cnt_walk = cnt;
        q_any    = 1'b0;
        ins_n    = '0;
        for (int i = 0; i < P_SPL; i++) begin
            if (sym_in[i] == q_sym) begin
                q_any = 1'b1;
                if (cnt_walk == '0) begin
                    sym_sub[i] = sr_sym;
                    ins_n      = ins_n + 3'd1;
                end
                cnt_walk = cnt_walk + CW'(1);
            end
        end
    end

    always_comb begin
        abort       = !CTL_EN_IN || CTL_TPS_IN || (CTL_MST_IN != mst_q);
        state_nxt   = state;
        cnt_d       = cnt;
        sym_nxt     = sym_in;
        scrm_en_nxt = 1'b0;
        sr_add      = '0;
        case (state)
            S_IDLE: begin
                cnt_d = '0;
                if (CTL_EN_IN && !CTL_TPS_IN)
                    state_nxt = S_WAIT_BS;
            end
            S_WAIT_BS: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    cnt_d     = '0;
                end else if (q_any) begin
                    state_nxt   = S_RUN;
                    cnt_d       = cnt_walk;
                    sym_nxt     = sym_sub;
                    scrm_en_nxt = 1'b1;
                    sr_add      = ins_n;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d       = cnt_walk;
                    sym_nxt     = sym_sub;
                    scrm_en_nxt = 1'b1;
                    sr_add      = ins_n;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_d     = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            state          <= S_IDLE;
            cnt            <= '0;
            mst_q          <= 1'b0;
            LNK_SYM_OUT    <= '0;
            LNK_DAT_OUT    <= '0;
            SCRM_EN_OUT    <= 1'b0;
            STA_SR_CNT_OUT <= '0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_d;
            mst_q          <= CTL_MST_IN;
            LNK_SYM_OUT    <= sym_nxt;
            LNK_DAT_OUT    <= LNK_DAT_IN;
            SCRM_EN_OUT    <= scrm_en_nxt;
            STA_SR_CNT_OUT <= sr_sum[16] ? 16'hFFFF : sr_sum[15:0];
        end
    end

endmodule

// File: tb/tb_prt_dptx_scrm_ctl.sv
// Randomized bench for prt_dptx_scrm_ctl (SPL=2, interval 512) against a
// reference model that counts qualifying symbols since enable with plain integers.
module tb_prt_dptx_scrm_ctl;

    localparam int SPL   = 2;
    localparam int INTVL = 512;
    localparam logic [4:0] DAT = 5'd0, BS = 5'd1, SR = 5'd2, MBS = 5'd3, MSR = 5'd4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 RST_IN, CTL_EN_IN, CTL_MST_IN, CTL_TPS_IN;
    logic [SPL*5-1:0]     LNK_SYM_IN, LNK_SYM_OUT;
    logic [SPL*8-1:0]     LNK_DAT_IN, LNK_DAT_OUT;
    logic                 SCRM_EN_OUT, STA_LOCK_OUT;
    logic [15:0]          STA_SR_CNT_OUT;

    prt_dptx_scrm_ctl #(.P_SIM(0), .P_SPL(SPL), .P_SYM_W(5), .P_SR_INTVL(INTVL)) dut (
        .CLK_IN(clk), .RST_IN(RST_IN), .CTL_EN_IN(CTL_EN_IN), .CTL_MST_IN(CTL_MST_IN),
        .CTL_TPS_IN(CTL_TPS_IN), .LNK_SYM_IN(LNK_SYM_IN), .LNK_DAT_IN(LNK_DAT_IN),
        .LNK_SYM_OUT(LNK_SYM_OUT), .LNK_DAT_OUT(LNK_DAT_OUT), .SCRM_EN_OUT(SCRM_EN_OUT),
        .STA_LOCK_OUT(STA_LOCK_OUT), .STA_SR_CNT_OUT(STA_SR_CNT_OUT)
    );

    int nchk = 0, npass = 0;

    // Model: active = enable sequence started; m_n = qualifying symbols seen since then.
    bit   m_act = 0, m_mst = 0;
    int   m_n = 0, m_srs = 0;
    logic [SPL-1:0][4:0] e_sym;
    logic [SPL*8-1:0]    e_dat;
    logic                e_en, e_lock;
    logic [15:0]         e_cnt;

    task automatic drive(input logic rst, input logic en, input logic mst, input logic tps,
                         input logic [SPL-1:0][4:0] sym, input logic [SPL*8-1:0] dat);
        logic [4:0] q, s;
        bit ab;
        RST_IN = rst; CTL_EN_IN = en; CTL_MST_IN = mst; CTL_TPS_IN = tps;
        LNK_SYM_IN = sym; LNK_DAT_IN = dat;
        e_sym = sym; e_dat = dat;
        if (rst) begin
            m_act = 0; m_n = 0; m_srs = 0; e_sym = '0; e_dat = '0;
        end else begin
            q  = mst ? MBS : BS;
            s  = mst ? MSR : SR;
            ab = !en || tps || (mst != m_mst);
            if (!m_act) begin
                m_act = en && !tps; m_n = 0;
            end else if (ab) begin
                m_act = 0; m_n = 0;
            end else begin
                for (int i = 0; i < SPL; i++)
                    if (sym[i] == q) begin
                        if (m_n % INTVL == 0) begin
                            e_sym[i] = s;
                            if (m_srs < 65535) m_srs++;
                        end
                        m_n++;
                    end
            end
        end
        m_mst  = rst ? 1'b0 : mst;
        e_en   = m_act && (m_n > 0);
        e_lock = e_en;
        e_cnt  = 16'(m_srs);
        @(posedge clk); #1;
    endtask

    function automatic logic [4:0] rsym(input logic [4:0] q);
        if ($urandom_range(0, 2) == 0) return q;
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1, 1, 0, 0, {BS, BS}, 16'hA5A5);
            nchk++;
            if ({LNK_SYM_OUT, LNK_DAT_OUT, SCRM_EN_OUT, STA_LOCK_OUT, STA_SR_CNT_OUT} !== '0)
                $display("FAIL reset c%0d: got sym=%h dat=%h en=%b lock=%b cnt=%0d, want all 0",
                         c, LNK_SYM_OUT, LNK_DAT_OUT, SCRM_EN_OUT, STA_LOCK_OUT, STA_SR_CNT_OUT);
            else npass++;
        end
    endtask

    task automatic test_sst_enable();
        int b = 0;
        for (int c = 1; c <= 9; c++) drive(0, 1, 0, 0, {DAT, DAT}, 16'(c));
        drive(0, 1, 0, 0, {BS, DAT}, 16'h1234);
        nchk++;
        if (LNK_SYM_OUT[9:5] !== SR || LNK_SYM_OUT[4:0] !== DAT || SCRM_EN_OUT !== 1'b1)
            $display("FAIL sst_first_sr: got sym=%h en=%b, want sym=%h en=1",
                     LNK_SYM_OUT, SCRM_EN_OUT, {SR, DAT});
        else npass++;
        while (m_n < 513 && b < 5000) begin
            drive(0, 1, 0, 0, {rsym(BS), rsym(BS)}, 16'($urandom));
            b++;
            nchk++;
            if ({LNK_SYM_OUT, LNK_DAT_OUT, SCRM_EN_OUT, STA_LOCK_OUT, STA_SR_CNT_OUT} !==
                {e_sym, e_dat, e_en, e_lock, e_cnt})
                $display("FAIL sst_beat%0d: got sym=%h dat=%h en=%b lock=%b cnt=%0d want sym=%h dat=%h en=%b lock=%b cnt=%0d",
                         b, LNK_SYM_OUT, LNK_DAT_OUT, SCRM_EN_OUT, STA_LOCK_OUT, STA_SR_CNT_OUT,
                         e_sym, e_dat, e_en, e_lock, e_cnt);
            else npass++;
        end
        nchk++;
        if (STA_SR_CNT_OUT !== 16'd2)
            $display("FAIL sst_sr_cnt: got %0d, want 2", STA_SR_CNT_OUT);
        else npass++;
    endtask

    task automatic test_mst();
        int srs = 0;
        logic [SPL-1:0][4:0] s;
        drive(0, 0, 1, 0, {DAT, DAT}, 16'h0);
        for (int b = 0; b < 24; b++) begin
            s = {DAT, DAT};
            s[b % SPL] = MBS;
            drive(0, 1, 1, 0, s, 16'($urandom));
            if (LNK_SYM_OUT[4:0] == MSR || LNK_SYM_OUT[9:5] == MSR) srs++;
            nchk++;
            if ({LNK_SYM_OUT, LNK_DAT_OUT, SCRM_EN_OUT, STA_LOCK_OUT, STA_SR_CNT_OUT} !==
                {e_sym, e_dat, e_en, e_lock, e_cnt})
                $display("FAIL mst_beat%0d: got sym=%h en=%b lock=%b cnt=%0d want sym=%h en=%b lock=%b cnt=%0d",
                         b, LNK_SYM_OUT, SCRM_EN_OUT, STA_LOCK_OUT, STA_SR_CNT_OUT,
                         e_sym, e_en, e_lock, e_cnt);
            else npass++;
        end
        nchk++;
        if (srs !== 1) $display("FAIL mst_sr_total: got %0d MTPH_SR, want 1", srs);
        else npass++;
    endtask

    task automatic test_tps_abort();
        int b = 0;
        drive(0, 0, 0, 0, {DAT, DAT}, 16'h0);
        while (m_n < 300 && b < 2000) begin
            drive(0, 1, 0, 0, {DAT, BS}, 16'($urandom));
            b++;
        end
        nchk++;
        if (STA_LOCK_OUT !== 1'b1 || SCRM_EN_OUT !== 1'b1)
            $display("FAIL tps_pre_run: got lock=%b en=%b, want 1 1", STA_LOCK_OUT, SCRM_EN_OUT);
        else npass++;
        drive(0, 1, 0, 1, {DAT, BS}, 16'h5555);
        nchk++;
        if (LNK_SYM_OUT !== {DAT, BS} || SCRM_EN_OUT !== 1'b0 || STA_LOCK_OUT !== 1'b0)
            $display("FAIL tps_abort: got sym=%h en=%b lock=%b, want sym=%h en=0 lock=0",
                     LNK_SYM_OUT, SCRM_EN_OUT, STA_LOCK_OUT, {DAT, BS});
        else npass++;
        drive(0, 1, 0, 0, {DAT, DAT}, 16'h6666);
        drive(0, 1, 0, 0, {DAT, BS}, 16'h7777);
        nchk++;
        if (LNK_SYM_OUT !== {DAT, SR} || SCRM_EN_OUT !== 1'b1 || LNK_DAT_OUT !== 16'h7777)
            $display("FAIL tps_resume: got sym=%h en=%b dat=%h, want sym=%h en=1 dat=7777",
                     LNK_SYM_OUT, SCRM_EN_OUT, LNK_DAT_OUT, {DAT, SR});
        else npass++;
    endtask

    task automatic test_back_to_back();
        int b = 0;
        drive(0, 0, 0, 0, {DAT, DAT}, 16'h0);
        while (m_n < 511 && b < 3000) begin
            drive(0, 1, 0, 0, {DAT, BS}, 16'($urandom));
            b++;
        end
        drive(0, 1, 0, 0, {BS, BS}, 16'hBEEF);
        nchk++;
        if (LNK_SYM_OUT !== {SR, BS} || SCRM_EN_OUT !== 1'b1)
            $display("FAIL b2b_pair: got sym=%h en=%b, want sym=%h en=1",
                     LNK_SYM_OUT, SCRM_EN_OUT, {SR, BS});
        else npass++;
        drive(0, 1, 0, 0, {DAT, BS}, 16'hCAFE);
        nchk++;
        if (LNK_SYM_OUT !== {DAT, BS} || STA_SR_CNT_OUT !== e_cnt)
            $display("FAIL b2b_next: got sym=%h cnt=%0d, want sym=%h cnt=%0d",
                     LNK_SYM_OUT, STA_SR_CNT_OUT, {DAT, BS}, e_cnt);
        else npass++;
    endtask

    task automatic test_mst_toggle();
        drive(0, 0, 0, 0, {DAT, DAT}, 16'h0);
        for (int c = 0; c < 4; c++) drive(0, 1, 0, 0, {BS, DAT}, 16'(c));
        drive(0, 1, 1, 0, {DAT, MBS}, 16'h1111);
        nchk++;
        if (LNK_SYM_OUT !== {DAT, MBS} || SCRM_EN_OUT !== 1'b0)
            $display("FAIL tog_abort: got sym=%h en=%b, want sym=%h en=0", LNK_SYM_OUT, SCRM_EN_OUT, {DAT, MBS});
        else npass++;
        drive(0, 1, 1, 0, {DAT, MBS}, 16'h2222);
        nchk++;
        if (LNK_SYM_OUT !== {DAT, MBS} || SCRM_EN_OUT !== 1'b0)
            $display("FAIL tog_idle: got sym=%h en=%b, want sym=%h en=0", LNK_SYM_OUT, SCRM_EN_OUT, {DAT, MBS});
        else npass++;
        drive(0, 1, 1, 0, {DAT, MBS}, 16'h3333);
        nchk++;
        if (LNK_SYM_OUT !== {DAT, MSR} || SCRM_EN_OUT !== 1'b1 || STA_LOCK_OUT !== 1'b1)
            $display("FAIL tog_rearm: got sym=%h en=%b lock=%b, want sym=%h en=1 lock=1",
                     LNK_SYM_OUT, SCRM_EN_OUT, STA_LOCK_OUT, {DAT, MSR});
        else npass++;
    endtask

    task automatic test_random();
        logic en = 1, mst = 1, tps = 0, rst;
        for (int b = 0; b < 3000; b++) begin
            if ($urandom_range(0, 99) < 2) en  = ~en;
            if ($urandom_range(0, 99) < 2) tps = ~tps;
            if ($urandom_range(0, 99) < 2) mst = ~mst;
            rst = ($urandom_range(0, 199) == 0);
            drive(rst, en, mst, tps, {rsym(mst ? MBS : BS), rsym(mst ? MBS : BS)}, 16'($urandom));
            nchk++;
            if ({LNK_SYM_OUT, LNK_DAT_OUT, SCRM_EN_OUT, STA_LOCK_OUT, STA_SR_CNT_OUT} !==
                {e_sym, e_dat, e_en, e_lock, e_cnt})
                $display("FAIL rnd_beat%0d: got sym=%h dat=%h en=%b lock=%b cnt=%0d want sym=%h dat=%h en=%b lock=%b cnt=%0d",
                         b, LNK_SYM_OUT, LNK_DAT_OUT, SCRM_EN_OUT, STA_LOCK_OUT, STA_SR_CNT_OUT,
                         e_sym, e_dat, e_en, e_lock, e_cnt);
            else npass++;
        end
    endtask

    initial begin
        test_reset();
        test_sst_enable();
        test_mst();
        test_tps_abort();
        test_back_to_back();
        test_mst_toggle();
        test_random();
        test_reset();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
